// File: rtl/snoop_bus_ctrl.sv
// rtl/snoop_bus_ctrl.sv - snooping bus controller, one transaction in flight; SNOOP_BUS_MEM_TIMEOUT_EN adds a memory wait timeout
module snoop_bus_ctrl #(
    parameter int NUM_CACHES  = 4,
    parameter int ADDR_W      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CACHES-1:0]        req_valid,
    input  logic [2*NUM_CACHES-1:0]      req_op,
    input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
    output logic [NUM_CACHES-1:0]        grant,
    output logic [NUM_CACHES-1:0]        done,
    output logic                         done_shared,
    output logic                         snoop_valid,
    output logic [1:0]                   snoop_op,
    output logic [ADDR_W-1:0]            snoop_addr,
    output logic [NUM_CACHES-1:0]        snoop_src,
    input  logic [NUM_CACHES-1:0]        snoop_shared,
    input  logic [NUM_CACHES-1:0]        snoop_flush,
    output logic                         mem_rd_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ready,
    output logic                         mem_wb,
    output logic                         bus_err
);

    localparam int RR_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam logic [1:0] OP_BUSRD   = 2'b01;
    localparam logic [1:0] OP_BUSUPGR = 2'b11;

    typedef enum logic [2:0] {IDLE, SNOOP, RESP, MEM, DONE} state_t;

    state_t                 state;
    logic [RR_W-1:0]        rr;
    logic [RR_W-1:0]        ownerIdx;
    logic [1:0]             curOp;
    logic [ADDR_W-1:0]      curAddr;
    logic                   shReg;

    logic [NUM_CACHES-1:0]  eligible;
    logic                   pickFound;
    logic [RR_W-1:0]        pickIdx;
    logic [RR_W-1:0]        candIdx;
    logic [1:0]             pickOp;
    logic [ADDR_W-1:0]      pickAddr;
    logic [NUM_CACHES-1:0]  pickOh;
    logic                   sh;
    logic                   fl;
    logic [RR_W-1:0]        rrNext;

`ifdef SNOOP_BUS_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    logic [TO_W-1:0]        memCnt;
`else
    logic                   unusedTimeout;
    assign unusedTimeout = (MEM_TIMEOUT > 0);
`endif

    // Eligible requesters and round-robin pick starting at rr
    always_comb begin
        eligible  = '0;
        pickFound = 1'b0;
        pickIdx   = '0;
        candIdx   = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            eligible[i] = req_valid[i] && (req_op[2*i +: 2] != 2'b00);
        end
        for (int i = 0; i < NUM_CACHES; i++) begin
            candIdx = RR_W'((int'(rr) + i) % NUM_CACHES);
            if (!pickFound && eligible[candIdx]) begin
                pickFound = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    // Operand mux for the picked requester, built from constant slices
    always_comb begin
        pickOp   = 2'b00;
        pickAddr = '0;
        pickOh   = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (pickIdx == RR_W'(i)) begin
                pickOp    = req_op[2*i +: 2];
                pickAddr  = req_addr[ADDR_W*i +: ADDR_W];
                pickOh[i] = 1'b1;
            end
        end
    end

    // The owner never answers its own snoop, so its response bits are masked off
    assign sh     = |(snoop_shared & ~grant);
    assign fl     = |(snoop_flush  & ~grant);
    assign rrNext = (ownerIdx == RR_W'(NUM_CACHES - 1)) ? '0 : ownerIdx + 1'b1;

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= '0;
            ownerIdx    <= '0;
            curOp       <= 2'b00;
            curAddr     <= '0;
            shReg       <= 1'b0;
            grant       <= '0;
            done        <= '0;
            done_shared <= 1'b0;
            snoop_valid <= 1'b0;
            snoop_op    <= 2'b00;
            snoop_addr  <= '0;
            snoop_src   <= '0;
            mem_rd_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wb      <= 1'b0;
            bus_err     <= 1'b0;
`ifdef SNOOP_BUS_MEM_TIMEOUT_EN
            memCnt      <= '0;
`endif
        end else begin
            done        <= '0;
            done_shared <= 1'b0;
            snoop_valid <= 1'b0;
            mem_wb      <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pickFound) begin
                        ownerIdx    <= pickIdx;
                        curOp       <= pickOp;
                        curAddr     <= pickAddr;
                        grant       <= pickOh;
                        snoop_valid <= 1'b1;
                        snoop_op    <= pickOp;
                        snoop_addr  <= pickAddr;
                        snoop_src   <= pickOh;
                        state       <= SNOOP;
                    end
                end
                SNOOP: begin
                    snoop_op   <= 2'b00;
                    snoop_addr <= '0;
                    snoop_src  <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    shReg <= sh;
                    if (fl) begin
                        done        <= grant;
                        done_shared <= (curOp == OP_BUSRD);
                        mem_wb      <= 1'b1;
                        mem_addr    <= curAddr;
                        state       <= DONE;
                    end else if (curOp == OP_BUSUPGR) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        mem_rd_req <= 1'b1;
                        mem_addr   <= curAddr;
`ifdef SNOOP_BUS_MEM_TIMEOUT_EN
                        memCnt     <= '0;
`endif
                        state      <= MEM;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_rd_req  <= 1'b0;
                        mem_addr    <= '0;
                        done        <= grant;
                        done_shared <= (curOp == OP_BUSRD) && shReg;
                        state       <= DONE;
`ifdef SNOOP_BUS_MEM_TIMEOUT_EN
                    end else if (memCnt == TO_W'(MEM_TIMEOUT - 1)) begin
                        mem_rd_req <= 1'b0;
                        mem_addr   <= '0;
                        done       <= grant;
                        bus_err    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        memCnt <= memCnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    grant    <= '0;
                    mem_addr <= '0;
                    rr       <= rrNext;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb/tb_snoop_bus_ctrl.sv - directed self-checking bench for snoop_bus_ctrl
module tb_snoop_bus_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [7:0]   req_op;
    logic [127:0] req_addr;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         done_shared;
    logic         snoop_valid;
    logic [1:0]   snoop_op;
    logic [31:0]  snoop_addr;
    logic [3:0]   snoop_src;
    logic [3:0]   snoop_shared;
    logic [3:0]   snoop_flush;
    logic         mem_rd_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic         mem_wb;
    logic         bus_err;

    int checks = 0;
    int failures = 0;

    snoop_bus_ctrl #(.NUM_CACHES(4), .ADDR_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .grant(grant), .done(done), .done_shared(done_shared), .snoop_valid(snoop_valid),
        .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
        .snoop_shared(snoop_shared), .snoop_flush(snoop_flush), .mem_rd_req(mem_rd_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_wb(mem_wb), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_addr = '0;
        snoop_shared = '0; snoop_flush = '0; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // k = MEM cycles before mem_ready is seen (0 = no memory phase expected)
    task automatic doTxn(input int own, input logic [1:0] op, input logic [31:0] addr,
                         input logic [3:0] sh, input logic [3:0] fl, input int k,
                         input logic expShared, input logic expWb);
        logic [3:0] ownOh;
        ownOh = 4'b0001 << own;
        req_valid[own] = 1'b1;
        req_op[2*own +: 2] = op;
        req_addr[32*own +: 32] = addr;
        tick();
        checkEq("snoop_valid", snoop_valid, 1);
        checkEq("snoop_src", snoop_src, ownOh);
        checkEq("snoop_addr", snoop_addr, addr);
        checkEq("snoop_op", snoop_op, op);
        checkEq("grant", grant, ownOh);
        req_addr[32*own +: 32] = addr ^ 32'h0000_FFF0;
        snoop_shared = sh;
        snoop_flush = fl;
        tick();
        checkEq("snoop_valid_pulse", snoop_valid, 0);
        checkEq("no_mem_in_resp", mem_rd_req, 0);
        tick();
        snoop_shared = '0;
        snoop_flush = '0;
        for (int j = 1; j <= k; j++) begin
            checkEq("mem_rd_req", mem_rd_req, 1);
            checkEq("mem_addr", mem_addr, addr);
            checkEq("grant_hold", grant, ownOh);
            checkEq("done_early", done, 0);
            if (j == k) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        checkEq("done", done, ownOh);
        checkEq("done_shared", done_shared, expShared);
        checkEq("mem_wb", mem_wb, expWb);
        checkEq("mem_rd_req_off", mem_rd_req, 0);
        checkEq("grant_in_done", grant, ownOh);
        checkEq("bus_err", bus_err, 0);
        if (expWb) checkEq("wb_addr", mem_addr, addr);
        req_valid[own] = 1'b0;
        req_op[2*own +: 2] = 2'b00;
        tick();
        checkEq("done_clear", done, 0);
        checkEq("grant_clear", grant, 0);
    endtask

    initial begin
        int order[$];
        int doneCnt[4];
        logic seenDone;
        logic seenErr;
        int memCycles;

        doReset();
        checkEq("rst_grant", grant, 0);
        checkEq("rst_done", done, 0);
        checkEq("rst_snoop_valid", snoop_valid, 0);
        checkEq("rst_snoop_addr", snoop_addr, 0);
        checkEq("rst_mem_rd_req", mem_rd_req, 0);
        checkEq("rst_mem_addr", mem_addr, 0);
        checkEq("rst_bus_err", bus_err, 0);

        // rr: 0 -> 2 -> 1 -> 0 -> 3 -> 3 -> 2 -> 1
        doTxn(1, 2'b01, 32'h40,  4'b0000, 4'b0000, 2, 1'b0, 1'b0);
        doTxn(0, 2'b01, 32'h80,  4'b0100, 4'b0100, 0, 1'b1, 1'b1);
        doTxn(3, 2'b11, 32'h100, 4'b1000, 4'b0000, 0, 1'b0, 1'b0);
        doTxn(2, 2'b01, 32'hC0,  4'b0010, 4'b0000, 1, 1'b1, 1'b0);
        doTxn(2, 2'b01, 32'hC4,  4'b0100, 4'b0100, 3, 1'b0, 1'b0);
        doTxn(1, 2'b10, 32'h44,  4'b0001, 4'b0000, 1, 1'b0, 1'b0);
        doTxn(0, 2'b11, 32'h48,  4'b0010, 4'b0000, 0, 1'b0, 1'b0);

        // op 00 is never granted
        req_valid = 4'b0001;
        tick(); tick();
        checkEq("op00_grant", grant, 0);
        checkEq("op00_snoop", snoop_valid, 0);

        // three simultaneous requesters from rr=0
        doReset();
        req_valid = 4'b1101;
        req_op = 8'b01_01_01_01;
        req_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) doneCnt[i] = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (done[i]) begin
                    order.push_back(i);
                    doneCnt[i]++;
                    req_valid[i] = 1'b0;
                end
            end
        end
        mem_ready = 1'b0;
        checkEq("rr_count", order.size(), 3);
        if (order.size() == 3) begin
            checkEq("rr_first", order[0], 0);
            checkEq("rr_second", order[1], 2);
            checkEq("rr_third", order[2], 3);
        end
        checkEq("once0", doneCnt[0], 1);
        checkEq("once1", doneCnt[1], 0);
        checkEq("once2", doneCnt[2], 1);
        checkEq("once3", doneCnt[3], 1);
        req_valid = 4'b0011;
        tick();
        checkEq("rr_wrap", snoop_src, 4'b0001);

        // reset during MEM aborts with no done
        doReset();
        req_valid = 4'b0010;
        req_op = 8'b00_00_10_00;
        req_addr = {32'h0, 32'h0, 32'h200, 32'h0};
        tick(); tick(); tick();
        checkEq("abort_in_mem", mem_rd_req, 1);
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        checkEq("abort_grant", grant, 0);
        checkEq("abort_mem_rd_req", mem_rd_req, 0);
        checkEq("abort_mem_addr", mem_addr, 0);
        checkEq("abort_snoop", snoop_valid, 0);
        seenDone = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seenDone = seenDone | (done != 0);
            tick();
        end
        checkEq("abort_no_done", seenDone, 0);
        doTxn(1, 2'b10, 32'h200, 4'b0000, 4'b0000, 1, 1'b0, 1'b0);

        // memory never answers (rr=2 now)
        req_valid[2] = 1'b1;
        req_op[5:4] = 2'b01;
        req_addr[95:64] = 32'h300;
        tick(); tick(); tick();
`ifdef SNOOP_BUS_MEM_TIMEOUT_EN
        memCycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (done != 0) break;
            if (mem_rd_req) memCycles++;
            tick();
        end
        checkEq("to_done", done, 4'b0100);
        checkEq("to_bus_err", bus_err, 1);
        checkEq("to_shared", done_shared, 0);
        checkEq("to_mem_cycles", memCycles, 16);
        req_valid = '0;
        tick();
        checkEq("to_err_pulse", bus_err, 0);
`else
        seenErr = 1'b0;
        seenDone = 1'b0;
        memCycles = 0;
        for (int c = 0; c < 30; c++) begin
            seenErr = seenErr | bus_err;
            seenDone = seenDone | (done != 0);
            tick();
        end
        checkEq("wait_mem_rd_req", mem_rd_req, 1);
        checkEq("wait_bus_err", seenErr, 0);
        checkEq("wait_no_done", seenDone, 0);
`endif
        doReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
